// File: rtl/xfcp_arb_2.sv
`default_nettype none
// ============================================================================
// Module   : xfcp_arb_2
// Purpose  : Two-port round-robin XFCP request arbiter with response routing.
// Revision : 1.0 - initial release
// ============================================================================
module xfcp_arb_2 #(
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic [7:0] up0_xfcp_in_tdata,
  input  logic       up0_xfcp_in_tvalid,
  output logic       up0_xfcp_in_tready,
  input  logic       up0_xfcp_in_tlast,
  input  logic       up0_xfcp_in_tuser,
  output logic [7:0] up0_xfcp_out_tdata,
  output logic       up0_xfcp_out_tvalid,
  input  logic       up0_xfcp_out_tready,
  output logic       up0_xfcp_out_tlast,
  output logic       up0_xfcp_out_tuser,

  input  logic [7:0] up1_xfcp_in_tdata,
  input  logic       up1_xfcp_in_tvalid,
  output logic       up1_xfcp_in_tready,
  input  logic       up1_xfcp_in_tlast,
  input  logic       up1_xfcp_in_tuser,
  output logic [7:0] up1_xfcp_out_tdata,
  output logic       up1_xfcp_out_tvalid,
  input  logic       up1_xfcp_out_tready,
  output logic       up1_xfcp_out_tlast,
  output logic       up1_xfcp_out_tuser,

  output logic [7:0] down_xfcp_out_tdata,
  output logic       down_xfcp_out_tvalid,
  input  logic       down_xfcp_out_tready,
  output logic       down_xfcp_out_tlast,
  output logic       down_xfcp_out_tuser,
  input  logic [7:0] down_xfcp_in_tdata,
  input  logic       down_xfcp_in_tvalid,
  output logic       down_xfcp_in_tready,
  input  logic       down_xfcp_in_tlast,
  input  logic       down_xfcp_in_tuser,

  output logic       busy,
  output logic [1:0] grant,
  output logic       timeout,
  output logic       stray
);

  localparam logic [1:0] c_S_IDLE      = 2'd0;
  localparam logic [1:0] c_S_FWD_REQ   = 2'd1;
  localparam logic [1:0] c_S_WAIT_RESP = 2'd2;

  localparam int               c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(TIMEOUT - 1);

  logic [1:0]         r_state, w_state_nxt;
  logic               r_gnt, w_gnt_nxt;    // index of the granted port
  logic               r_last, w_last_nxt;  // round-robin history bit
  logic               r_run;               // low until the first clock after reset
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_idle, w_fwd, w_wait;
  logic [7:0] w_req_tdata;
  logic       w_req_tvalid, w_req_tlast, w_req_tuser;
  logic       w_rsp_rdy, w_req_hs, w_rsp_hs, w_to_hit;

  assign w_idle = (r_state == c_S_IDLE);
  assign w_fwd  = (r_state == c_S_FWD_REQ);
  assign w_wait = (r_state == c_S_WAIT_RESP);

  assign w_req_tdata  = r_gnt ? up1_xfcp_in_tdata  : up0_xfcp_in_tdata;
  assign w_req_tvalid = r_gnt ? up1_xfcp_in_tvalid : up0_xfcp_in_tvalid;
  assign w_req_tlast  = r_gnt ? up1_xfcp_in_tlast  : up0_xfcp_in_tlast;
  assign w_req_tuser  = r_gnt ? up1_xfcp_in_tuser  : up0_xfcp_in_tuser;
  assign w_rsp_rdy    = r_gnt ? up1_xfcp_out_tready : up0_xfcp_out_tready;

  assign w_req_hs = w_fwd & w_req_tvalid & down_xfcp_out_tready;
  assign w_rsp_hs = w_wait & down_xfcp_in_tvalid & w_rsp_rdy;
  assign w_to_hit = (TIMEOUT > 0) && w_wait && !w_rsp_hs && (r_cnt == c_CNT_END);

  assign down_xfcp_out_tdata  = w_req_tdata;
  assign down_xfcp_out_tvalid = w_fwd & w_req_tvalid;
  assign down_xfcp_out_tlast  = w_req_tlast;
  assign down_xfcp_out_tuser  = w_req_tuser;
  assign up0_xfcp_in_tready   = w_fwd & ~r_gnt & down_xfcp_out_tready;
  assign up1_xfcp_in_tready   = w_fwd &  r_gnt & down_xfcp_out_tready;

  assign up0_xfcp_out_tdata   = down_xfcp_in_tdata;
  assign up0_xfcp_out_tvalid  = w_wait & ~r_gnt & down_xfcp_in_tvalid;
  assign up0_xfcp_out_tlast   = down_xfcp_in_tlast;
  assign up0_xfcp_out_tuser   = down_xfcp_in_tuser;
  assign up1_xfcp_out_tdata   = down_xfcp_in_tdata;
  assign up1_xfcp_out_tvalid  = w_wait &  r_gnt & down_xfcp_in_tvalid;
  assign up1_xfcp_out_tlast   = down_xfcp_in_tlast;
  assign up1_xfcp_out_tuser   = down_xfcp_in_tuser;

  // Unsolicited responses are sunk while idle so they cannot block the tree.
  assign down_xfcp_in_tready = (w_wait & w_rsp_rdy) | (w_idle & r_run);

  assign busy    = ~w_idle;
  assign grant   = w_idle ? 2'b00 : (r_gnt ? 2'b10 : 2'b01);
  assign timeout = w_to_hit;
  assign stray   = w_idle & r_run & down_xfcp_in_tvalid & down_xfcp_in_tlast;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_S_IDLE: begin
        if (up0_xfcp_in_tvalid | up1_xfcp_in_tvalid) begin
          w_state_nxt = c_S_FWD_REQ;
          w_gnt_nxt   = (up0_xfcp_in_tvalid & up1_xfcp_in_tvalid) ? ~r_last : up1_xfcp_in_tvalid;
        end
      end
      c_S_FWD_REQ: begin
        if (w_req_hs & w_req_tlast) begin
          w_state_nxt = c_S_WAIT_RESP;
          w_last_nxt  = r_gnt;
          w_cnt_nxt   = '0;
        end
      end
      c_S_WAIT_RESP: begin
        if (w_rsp_hs) begin
          w_cnt_nxt = '0;
          if (down_xfcp_in_tlast) w_state_nxt = c_S_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = c_S_IDLE;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_run   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_run   <= 1'b1;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xfcp_arb_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_xfcp_arb_2
// Purpose  : Randomized scoreboard bench for the two-port XFCP arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xfcp_arb_2;

  localparam int TO = 16;

  typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;
  typedef struct packed { logic p; beat_t b; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  logic [7:0] ui_d[2];
  logic       ui_v[2], ui_l[2], ui_u[2], ui_r[2];
  logic [7:0] uo_d[2];
  logic       uo_v[2], uo_l[2], uo_u[2], uo_r[2];
  logic [7:0] do_d, di_d;
  logic       do_v, do_r, do_l, do_u, di_v, di_r, di_l, di_u;
  logic       busy, timeout, stray;
  logic [1:0] grant;

  xfcp_arb_2 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .up0_xfcp_in_tdata(ui_d[0]), .up0_xfcp_in_tvalid(ui_v[0]), .up0_xfcp_in_tready(ui_r[0]),
    .up0_xfcp_in_tlast(ui_l[0]), .up0_xfcp_in_tuser(ui_u[0]),
    .up0_xfcp_out_tdata(uo_d[0]), .up0_xfcp_out_tvalid(uo_v[0]), .up0_xfcp_out_tready(uo_r[0]),
    .up0_xfcp_out_tlast(uo_l[0]), .up0_xfcp_out_tuser(uo_u[0]),
    .up1_xfcp_in_tdata(ui_d[1]), .up1_xfcp_in_tvalid(ui_v[1]), .up1_xfcp_in_tready(ui_r[1]),
    .up1_xfcp_in_tlast(ui_l[1]), .up1_xfcp_in_tuser(ui_u[1]),
    .up1_xfcp_out_tdata(uo_d[1]), .up1_xfcp_out_tvalid(uo_v[1]), .up1_xfcp_out_tready(uo_r[1]),
    .up1_xfcp_out_tlast(uo_l[1]), .up1_xfcp_out_tuser(uo_u[1]),
    .down_xfcp_out_tdata(do_d), .down_xfcp_out_tvalid(do_v), .down_xfcp_out_tready(do_r),
    .down_xfcp_out_tlast(do_l), .down_xfcp_out_tuser(do_u),
    .down_xfcp_in_tdata(di_d), .down_xfcp_in_tvalid(di_v), .down_xfcp_in_tready(di_r),
    .down_xfcp_in_tlast(di_l), .down_xfcp_in_tuser(di_u),
    .busy(busy), .grant(grant), .timeout(timeout), .stray(stray)
  );

  int nvec = 0;
  int nerr = 0;

  beat_t uq[2][$];   // request beats each upstream source still has to send
  beat_t dq[$];      // beats the downstream model presents on down_xfcp_in
  beat_t ovr_q[$];   // fixed content for the next generated response
  int    need_q[$];  // ports whose request completed and awaits a response
  exp_t  exp_req[$];
  exp_t  exp_rsp[$];
  bit    resp_en = 1'b1;
  bit    m_last  = 1'b1;  // reference round-robin history
  int    n_stray = 0, n_to = 0, to_cyc = 0, req_end_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Upstream sources: first beat of a packet is presented without gaps.
  initial begin : p_up_drv
    bit hs[2];
    bit at_start[2];
    for (int p = 0; p < 2; p++) begin
      ui_v[p] = 0; ui_d[p] = 0; ui_l[p] = 0; ui_u[p] = 0; uo_r[p] = 0; at_start[p] = 1;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) hs[p] = ui_v[p] && ui_r[p];
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (hs[p] && uq[p].size() > 0) begin
          at_start[p] = uq[p][0].l;
          void'(uq[p].pop_front());
        end
        if (uq[p].size() == 0) at_start[p] = 1;
        if (uq[p].size() > 0) begin
          ui_v[p] = at_start[p] || ($urandom_range(0, 3) != 0);
          ui_d[p] = uq[p][0].d; ui_l[p] = uq[p][0].l; ui_u[p] = uq[p][0].u;
        end else begin
          ui_v[p] = 0; ui_d[p] = 0; ui_l[p] = 0; ui_u[p] = 0;
        end
        uo_r[p] = ($urandom_range(0, 4) != 0);
      end
    end
  end

  // Downstream model: answers each completed request with a fresh packet.
  initial begin : p_down_drv
    bit hs;
    int p, n;
    beat_t b;
    exp_t e;
    di_v = 0; di_d = 0; di_l = 0; di_u = 0; do_r = 0;
    forever begin
      @(negedge clk);
      hs = di_v && di_r;
      @(posedge clk); #1;
      if (hs && dq.size() > 0) void'(dq.pop_front());
      if (dq.size() == 0 && need_q.size() > 0) begin
        p = need_q.pop_front();
        if (ovr_q.size() > 0) begin
          do begin
            b = ovr_q.pop_front();
            dq.push_back(b);
            e.p = p[0]; e.b = b; exp_rsp.push_back(e);
          end while (!b.l && ovr_q.size() > 0);
        end else begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) begin
            b.d = 8'($urandom); b.l = (i == n - 1); b.u = 1'($urandom);
            dq.push_back(b);
            e.p = p[0]; e.b = b; exp_rsp.push_back(e);
          end
        end
      end
      if (dq.size() > 0) begin
        di_v = ($urandom_range(0, 4) != 0);
        di_d = dq[0].d; di_l = dq[0].l; di_u = dq[0].u;
      end else begin
        di_v = 0; di_d = 0; di_l = 0; di_u = 0;
      end
      do_r = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor.
  initial begin : p_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stray) n_stray++;
        if (timeout) begin n_to++; to_cyc = cyc; end
        if (do_v && do_r) begin
          chk("req_pending", 32'(exp_req.size() > 0), 1);
          if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            chk("req_beat", 32'({do_d, do_l, do_u}), 32'(e.b));
            chk("req_grant", 32'(grant), e.p ? 2 : 1);
            if (e.b.l) begin
              req_end_cyc = cyc;
              if (resp_en) need_q.push_back(int'(e.p));
            end
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (uo_v[p] && uo_r[p]) begin
            chk("rsp_pending", 32'(exp_rsp.size() > 0), 1);
            if (exp_rsp.size() > 0) begin
              e = exp_rsp.pop_front();
              chk("rsp_port", p, 32'(e.p));
              chk("rsp_beat", 32'({uo_d[p], uo_l[p], uo_u[p]}), 32'(e.b));
            end
          end else if (uo_v[p] && (exp_rsp.size() == 0 || exp_rsp[0].p != p[0])) begin
            nvec++; nerr++;
            $display("FAIL rsp_valid: tvalid on port %0d with no response due there (cycle %0d)", p, cyc);
          end
        end
      end
    end
  end

  // Reference arbitration: alternate while both have work, else serve whoever has.
  task automatic load(input int n0, input int n1, input int lmin, input int lmax);
    int k[2];
    int p, len;
    beat_t b;
    exp_t e;
    k[0] = n0; k[1] = n1;
    while (k[0] + k[1] > 0) begin
      if (k[0] > 0 && k[1] > 0) p = m_last ? 0 : 1;
      else p = (k[0] > 0) ? 0 : 1;
      m_last = p[0];
      k[p]--;
      len = $urandom_range(lmin, lmax);
      for (int i = 0; i < len; i++) begin
        b.d = 8'($urandom); b.l = (i == len - 1); b.u = 1'($urandom);
        uq[p].push_back(b);
        e.p = p[0]; e.b = b; exp_req.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_req.size() > 0 || exp_rsp.size() > 0 || need_q.size() > 0 ||
            dq.size() > 0 || busy) && t < 3000) begin
      @(negedge clk); t++;
    end
    chk({name, "_drain"}, 32'(t < 3000), 1);
  endtask

  task automatic check_reset_outs(input string name);
    chk(name, 32'({do_v, ui_r[0], ui_r[1], uo_v[0], uo_v[1], di_r, busy, grant, timeout, stray}), 0);
  endtask

  task automatic inject(input string name, input int n);
    int s0, t;
    beat_t b;
    s0 = n_stray;
    for (int i = 0; i < n; i++) begin
      b.d = 8'($urandom); b.l = (i == n - 1); b.u = 1'($urandom);
      dq.push_back(b);
    end
    t = 0;
    while (dq.size() > 0 && t < 200) begin
      @(negedge clk); t++;
      if (di_v) chk({name, "_rdy"}, 32'(di_r), 1);
    end
    @(negedge clk);
    chk({name, "_count"}, n_stray - s0, 1);
  endtask

  initial begin : p_main
    beat_t b;
    exp_t e;
    logic [7:0] dreq[4];
    logic [7:0] drsp[3];
    int t, to0;
    dreq[0] = 8'h10; dreq[1] = 8'h00; dreq[2] = 8'h00; dreq[3] = 8'h01;
    drsp[0] = 8'h11; drsp[1] = 8'h00; drsp[2] = 8'hAA;

    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs");
    load(3, 3, 1, 6);  // both ports valid when reset releases
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("rr");

    // Directed transaction on port 0 with a fixed response.
    for (int i = 0; i < 4; i++) begin
      b.d = dreq[i]; b.l = (i == 3); b.u = 1'b0;
      uq[0].push_back(b);
      e.p = 1'b0; e.b = b; exp_req.push_back(e);
    end
    m_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b.d = drsp[i]; b.l = (i == 2); b.u = 1'b0;
      ovr_q.push_back(b);
    end
    @(negedge clk);
    chk("lat_idle", 32'({busy, do_v}), 0);
    @(negedge clk);
    chk("lat_grant", 32'({do_v, grant}), 32'({1'b1, 2'b01}));
    wait_drain("dir");
    chk("dir_idle", 32'({busy, grant}), 0);

    for (int r = 0; r < 8; r++) begin
      load($urandom_range(0, 3), $urandom_range(0, 3), 1, 6);
      wait_drain("rand");
    end
    chk("no_stray", n_stray, 0);
    chk("no_timeout", n_to, 0);

    // Abandoned transaction, then its late response is dropped.
    resp_en = 1'b0;
    to0 = n_to;
    load(0, 1, 1, 4);
    t = 0;
    while (n_to == to0 && t < 500) begin @(negedge clk); t++; end
    chk("to_seen", n_to - to0, 1);
    chk("to_latency", to_cyc - req_end_cyc, TO);
    chk("to_busy_hold", 32'(busy), 1);
    @(negedge clk);
    chk("to_busy_fall", 32'(busy), 0);
    resp_en = 1'b1;
    inject("late_stray", 3);
    chk("to_single", n_to - to0, 1);

    inject("idle_stray", 2);

    // Asynchronous reset in the middle of a request packet.
    load(0, 1, 8, 8);
    t = 0;
    while (exp_req.size() > 6 && t < 200) begin @(negedge clk); t++; end
    chk("mid_fwd_reached", 32'(busy && exp_req.size() <= 6), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("mid_reset_outs");
    uq[0].delete(); uq[1].delete(); dq.delete(); need_q.delete(); ovr_q.delete();
    exp_req.delete(); exp_rsp.delete();
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    load(1, 1, 1, 6);
    rst_n = 1'b1;
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
